// File: rtl/uart_measurement_reporter_if.sv
// Byte-stream bundle between the measurement reporter and the UART.
// The RX command stream and the TX response stream both use valid/ready.
// The reporter takes the master modport; the UART side takes the slave modport.
interface uart_measurement_reporter_if #(
   parameter int unsigned DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] rx_data;
   logic                  rx_valid;
   logic                  rx_ready;
   logic [DATA_WIDTH-1:0] tx_data;
   logic                  tx_valid;
   logic                  tx_ready;

   modport master (
      input  rx_data, rx_valid, tx_ready,
      output rx_ready, tx_data, tx_valid
   );

   modport slave (
      output rx_data, rx_valid, tx_ready,
      input  rx_ready, tx_data, tx_valid
   );
endinterface

// File: rtl/uart_measurement_reporter.sv
// Command-driven measurement reporter.
// A single-byte ASCII command ('H', 'L', 'P' or 'A') snapshots the three
// measurement registers. The block then streams a tagged, big-endian,
// XOR-checksummed frame terminated by 0x0A. An unknown byte answers "?\n"
// and pulses cmd_err. Only one command is handled at a time; RX is
// back-pressured until the frame's final byte has transferred.
module uart_measurement_reporter #(
   parameter int unsigned COUNTER_BITS = 32,
   parameter int unsigned DATA_WIDTH   = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   uart_measurement_reporter_if.master   uart,
   input  logic [COUNTER_BITS-1:0]       time_high,
   input  logic [COUNTER_BITS-1:0]       time_low,
   input  logic [COUNTER_BITS-1:0]       period,
   output logic                          busy,
   output logic                          cmd_err
);

   localparam int unsigned NB    = COUNTER_BITS / 8;
   localparam int unsigned CNT_W = (NB > 1) ? $clog2(NB) : 1;

   typedef logic [DATA_WIDTH-1:0] byte_t;

   localparam byte_t CH_H   = byte_t'(8'h48);
   localparam byte_t CH_L   = byte_t'(8'h4C);
   localparam byte_t CH_P   = byte_t'(8'h50);
   localparam byte_t CH_A   = byte_t'(8'h41);
   localparam byte_t CH_Q   = byte_t'(8'h3F);
   localparam byte_t CH_EOL = byte_t'(8'h0A);

   typedef enum logic [2:0] {IDLE, TAG, DATA, CSUM, ERR, EOL} state_t;

   state_t            state;
   logic [1:0]        sel;        // current sub-frame: 0=high, 1=low, 2=period
   logic              all_mode;   // 'A' command: walk all three sub-frames
   logic [CNT_W-1:0]  idx;        // data byte index within a sub-frame
   byte_t             csum;
   logic [COUNTER_BITS-1:0] snap_high;
   logic [COUNTER_BITS-1:0] snap_low;
   logic [COUNTER_BITS-1:0] snap_period;

   logic  xfer;
   logic  accept;
   byte_t csum_next;

   // Handshake decode and running checksum including the byte now on tx_data.
   always_comb begin
      xfer      = uart.tx_valid & uart.tx_ready;
      accept    = uart.rx_valid & uart.rx_ready;
      csum_next = csum ^ uart.tx_data;
   end

   function automatic byte_t tag_of(input logic [1:0] s);
      case (s)
         2'd0:    return CH_H;
         2'd1:    return CH_L;
         default: return CH_P;
      endcase
   endfunction

   // Big-endian byte i of the snapshot selected by s.
   function automatic byte_t data_of(input logic [1:0] s, input logic [CNT_W-1:0] i);
      logic [COUNTER_BITS-1:0] word;
      int unsigned             sh;
      case (s)
         2'd0:    word = snap_high;
         2'd1:    word = snap_low;
         default: word = snap_period;
      endcase
      sh = (NB - 1 - 32'(i)) * 8;
      return word[sh +: 8];
   endfunction

   // Response FSM. The byte for the next state is loaded on the transfer edge,
   // so tx_data is already valid in the cycle after each transfer.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= IDLE;
         sel           <= '0;
         all_mode      <= 1'b0;
         idx           <= '0;
         csum          <= '0;
         snap_high     <= '0;
         snap_low      <= '0;
         snap_period   <= '0;
         uart.rx_ready <= 1'b0;
         uart.tx_valid <= 1'b0;
         uart.tx_data  <= '0;
         busy          <= 1'b0;
         cmd_err       <= 1'b0;
      end else begin
         cmd_err <= 1'b0;
         case (state)
            IDLE: begin
               uart.rx_ready <= 1'b1;
               if (accept) begin
                  snap_high     <= time_high;
                  snap_low      <= time_low;
                  snap_period   <= period;
                  csum          <= '0;
                  idx           <= '0;
                  all_mode      <= 1'b0;
                  uart.rx_ready <= 1'b0;
                  uart.tx_valid <= 1'b1;
                  uart.tx_data  <= uart.rx_data;
                  busy          <= 1'b1;
                  state         <= TAG;
                  case (uart.rx_data)
                     CH_H: sel <= 2'd0;
                     CH_L: sel <= 2'd1;
                     CH_P: sel <= 2'd2;
                     CH_A: begin
                        sel          <= 2'd0;
                        all_mode     <= 1'b1;
                        uart.tx_data <= CH_H;
                     end
                     default: begin
                        uart.tx_data <= CH_Q;
                        cmd_err      <= 1'b1;
                        state        <= ERR;
                     end
                  endcase
               end
            end
            TAG: begin
               if (xfer) begin
                  csum         <= csum_next;
                  idx          <= '0;
                  uart.tx_data <= data_of(sel, '0);
                  state        <= DATA;
               end
            end
            DATA: begin
               if (xfer) begin
                  csum <= csum_next;
                  if (idx == CNT_W'(NB - 1)) begin
                     if (all_mode && sel != 2'd2) begin
                        sel          <= 2'(sel + 2'd1);
                        uart.tx_data <= tag_of(2'(sel + 2'd1));
                        state        <= TAG;
                     end else begin
                        uart.tx_data <= csum_next;
                        state        <= CSUM;
                     end
                  end else begin
                     idx          <= CNT_W'(idx + 1'b1);
                     uart.tx_data <= data_of(sel, CNT_W'(idx + 1'b1));
                  end
               end
            end
            CSUM, ERR: begin
               if (xfer) begin
                  uart.tx_data <= CH_EOL;
                  state        <= EOL;
               end
            end
            EOL: begin
               if (xfer) begin
                  uart.tx_valid <= 1'b0;
                  uart.tx_data  <= '0;
                  uart.rx_ready <= 1'b1;
                  busy          <= 1'b0;
                  state         <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
